// File: rtl/sc_road_scroll_ctrl.sv
// sc_road_scroll_ctrl: sequences clear/load/shift of the background bank and paces the scroll speed per level.
module sc_road_scroll_ctrl #(
  parameter int PRESCALER_DATAWIDTH = 23,
  parameter logic [PRESCALER_DATAWIDTH-1:0] SPEED_BASE = 23'd5_000_000,
  parameter logic [PRESCALER_DATAWIDTH-1:0] SPEED_STEP = 23'd500_000,
  parameter logic [PRESCALER_DATAWIDTH-1:0] SPEED_MIN = 23'd1_000_000,
  parameter int ROWS_PER_LEVEL = 8,
  parameter int LEVEL_WIDTH = 3
) (
  input  logic                   sc_road_scroll_ctrl_CLOCK_50,
  input  logic                   sc_road_scroll_ctrl_RESET_InLow,
  input  logic                   sc_road_scroll_ctrl_start_In,
  input  logic                   sc_road_scroll_ctrl_crash_In,
  input  logic                   sc_road_scroll_ctrl_bottomside_In,
  output logic                   sc_road_scroll_ctrl_clear_Out,
  output logic                   sc_road_scroll_ctrl_load_Out,
  output logic [1:0]             sc_road_scroll_ctrl_shiftselection_Out,
  output logic [LEVEL_WIDTH-1:0] sc_road_scroll_ctrl_level_Out,
  output logic                   sc_road_scroll_ctrl_running_Out,
  output logic                   sc_road_scroll_ctrl_gameover_Out
);
  localparam int CW = $clog2(ROWS_PER_LEVEL + 1);
  localparam logic [PRESCALER_DATAWIDTH:0] minPlusStep = {1'b0, SPEED_MIN} + {1'b0, SPEED_STEP};
  typedef enum logic [2:0] {IDLE, INIT_CLR, INIT_LOAD, WAIT, SHIFT, CHECK, GAMEOVER} stateT;
  stateT state;
  logic [PRESCALER_DATAWIDTH-1:0] prescaler, threshold;
  logic [CW-1:0] shiftCnt;
  logic [LEVEL_WIDTH-1:0] level;
  logic startQ, startEdge;
  assign startEdge = sc_road_scroll_ctrl_start_In & ~startQ;
  always_ff @(posedge sc_road_scroll_ctrl_CLOCK_50 or negedge sc_road_scroll_ctrl_RESET_InLow)
    if (!sc_road_scroll_ctrl_RESET_InLow) begin
      state     <= IDLE;
      prescaler <= '0;
      threshold <= SPEED_BASE;
      shiftCnt  <= '0;
      level     <= '0;
      startQ    <= 1'b0;
    end else begin
      startQ <= sc_road_scroll_ctrl_start_In;
      case (state)
        IDLE, GAMEOVER:
          if (startEdge) begin
            level     <= '0;
            threshold <= SPEED_BASE;
            shiftCnt  <= '0;
            state     <= INIT_CLR;
          end
        INIT_CLR: state <= INIT_LOAD;
        INIT_LOAD: begin
          prescaler <= '0;
          state     <= WAIT;
        end
        WAIT:
          if (sc_road_scroll_ctrl_crash_In) state <= GAMEOVER;
          else if (prescaler == threshold - PRESCALER_DATAWIDTH'(1)) begin
            prescaler <= '0;
            state     <= SHIFT;
          end else prescaler <= prescaler + 1'b1;
        SHIFT: begin
          shiftCnt <= shiftCnt + 1'b1;
          state    <= CHECK;
        end
        CHECK: begin
          if (shiftCnt == CW'(ROWS_PER_LEVEL)) begin
            shiftCnt  <= '0;
            level     <= (&level) ? level : level + 1'b1;
            threshold <= ({1'b0, threshold} < minPlusStep) ? SPEED_MIN : threshold - SPEED_STEP;
          end
          // bottom reached: reload the bank without clearing it
          state <= sc_road_scroll_ctrl_bottomside_In ? INIT_LOAD : WAIT;
        end
        default: state <= IDLE;
      endcase
    end
  assign sc_road_scroll_ctrl_clear_Out          = state == INIT_CLR;
  assign sc_road_scroll_ctrl_load_Out           = state == INIT_LOAD;
  assign sc_road_scroll_ctrl_shiftselection_Out = {1'b0, state == SHIFT};
  assign sc_road_scroll_ctrl_level_Out          = level;
  assign sc_road_scroll_ctrl_running_Out        = !(state == IDLE || state == GAMEOVER);
  assign sc_road_scroll_ctrl_gameover_Out       = state == GAMEOVER;
endmodule

// File: tb/tb_sc_road_scroll_ctrl.sv
// tb_sc_road_scroll_ctrl: directed checks of start, acceleration, reload, crash and reset with small speed constants.
module tb_sc_road_scroll_ctrl;
  logic clk = 0, rstN = 1, start = 0, crash = 0, bottom = 0;
  logic clear, load, running, gameover;
  logic [1:0] shiftSel, level;
  int cyc = 0, nCmp = 0, nBad = 0, n = 0, s = 0;
  int shiftQ[$], lvlQ[$], clearQ[$], loadQ[$];
  int shiftExp[8] = '{12, 24, 33, 42, 49, 55, 61, 67};
  int lvlExp[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
  int restartExp[4] = '{12, 24, 33, 42};

  sc_road_scroll_ctrl #(
    .SPEED_BASE(23'd10), .SPEED_STEP(23'd3), .SPEED_MIN(23'd4),
    .ROWS_PER_LEVEL(2), .LEVEL_WIDTH(2)
  ) dut (
    .sc_road_scroll_ctrl_CLOCK_50(clk),
    .sc_road_scroll_ctrl_RESET_InLow(rstN),
    .sc_road_scroll_ctrl_start_In(start),
    .sc_road_scroll_ctrl_crash_In(crash),
    .sc_road_scroll_ctrl_bottomside_In(bottom),
    .sc_road_scroll_ctrl_clear_Out(clear),
    .sc_road_scroll_ctrl_load_Out(load),
    .sc_road_scroll_ctrl_shiftselection_Out(shiftSel),
    .sc_road_scroll_ctrl_level_Out(level),
    .sc_road_scroll_ctrl_running_Out(running),
    .sc_road_scroll_ctrl_gameover_Out(gameover)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // event log: cyc at a negedge equals the number of rising edges so far
  always @(negedge clk) begin
    if (shiftSel == 2'b01) begin
      shiftQ.push_back(cyc);
      lvlQ.push_back(int'(level));
    end
    if (clear) clearQ.push_back(cyc);
    if (load) loadQ.push_back(cyc);
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input int exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic waitShifts(input int cnt);
    for (int i = 0; i < 60 && shiftQ.size() < cnt; i++) tick(1);
    checkVal("shift_seen", shiftQ.size(), cnt);
  endtask

  task automatic checkAllLow(input string tag);
    checkVal({tag, "_clear"}, clear, 0);
    checkVal({tag, "_load"}, load, 0);
    checkVal({tag, "_shsel"}, shiftSel, 0);
    checkVal({tag, "_level"}, level, 0);
    checkVal({tag, "_running"}, running, 0);
    checkVal({tag, "_gameover"}, gameover, 0);
  endtask

  task automatic clearLogs();
    shiftQ.delete();
    lvlQ.delete();
    clearQ.delete();
    loadQ.delete();
  endtask

  initial begin
    #1 rstN = 0;
    #2 checkAllLow("rst");
    tick(3);
    rstN = 1;
    tick(5);
    checkVal("idle_clears", clearQ.size(), 0);
    checkVal("idle_loads", loadQ.size(), 0);
    checkVal("idle_shifts", shiftQ.size(), 0);
    checkVal("idle_running", running, 0);

    // start sampled at edge n; start stays high through two shifts
    start = 1;
    n = cyc + 1;
    for (int k = 1; k <= 8; k++) begin
      waitShifts(k);
      if (k == 2) start = 0;
      if (k == 4) begin
        bottom = 1;
        @(posedge clk);
        @(posedge clk);
        #1 bottom = 0;
      end
    end
    for (int k = 0; k < 8; k++) begin
      checkVal($sformatf("shift%0d_time", k + 1), shiftQ[k] - n, shiftExp[k]);
      checkVal($sformatf("shift%0d_level", k + 1), lvlQ[k], lvlExp[k]);
    end
    checkVal("clear_count", clearQ.size(), 1);
    checkVal("clear_time", clearQ[0] - n, 0);
    checkVal("load_count", loadQ.size(), 2);
    checkVal("load_time", loadQ[0] - n, 1);
    checkVal("reload_time", loadQ[1] - n, 44);

    // crash in the middle of WAIT after shift 8
    s = shiftQ[7];
    tick(3);
    checkVal("sat_level", level, 3);
    crash = 1;
    tick(1);
    checkVal("crash_gameover", gameover, 1);
    checkVal("crash_running", running, 0);
    checkVal("crash_time", cyc - s, 4);
    crash = 0;
    tick(100);
    checkVal("go_no_shift", shiftQ.size(), 8);
    checkVal("go_held", gameover, 1);
    checkVal("go_level", level, 3);

    clearLogs();
    start = 1;
    n = cyc + 1;
    tick(1);
    start = 0;
    checkVal("rs_gameover", gameover, 0);
    for (int k = 1; k <= 4; k++) waitShifts(k);
    checkVal("rs_clear", clearQ[0] - n, 0);
    checkVal("rs_load", loadQ[0] - n, 1);
    for (int k = 0; k < 4; k++) begin
      checkVal($sformatf("rs_shift%0d_time", k + 1), shiftQ[k] - n, restartExp[k]);
      checkVal($sformatf("rs_shift%0d_level", k + 1), lvlQ[k], lvlExp[k]);
    end
    tick(3);
    checkVal("pre_rst_level", level, 2);
    checkVal("pre_rst_running", running, 1);

    rstN = 0;
    #1 checkAllLow("midrst");
    tick(1);
    rstN = 1;
    tick(2);
    clearLogs();
    start = 1;
    n = cyc + 1;
    tick(1);
    start = 0;
    waitShifts(2);
    checkVal("post_rst_first", shiftQ[0] - n, 12);
    checkVal("post_rst_period", shiftQ[1] - shiftQ[0], 12);
    checkVal("post_rst_level", lvlQ[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
